fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer: owns the architectural PC and drives one instruction-memory

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   RESET_PC_DEFAULT : address of the first fetch after reset
//   S_REQ/S_WAIT/S_HOLD : FSM state encoding (2-bit)
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef logic [1:0] state_t;

  localparam state_t S_REQ  = 2'd0;  // issuing a fetch request
  localparam state_t S_WAIT = 2'd1;  // one request outstanding
  localparam state_t S_HOLD = 2'd2;  // instruction offered to decode

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the architectural PC, issues one instruction-memory request
// at a time, holds the returned word for decode and applies redirects from execute, squashing
// wrong-path fetches.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   imem_req_valid_o/ready_i    request handshake, imem_req_addr_o = pc
//   imem_rsp_valid_i/data_i/err_i  response (exactly one per accepted request)
//   redirect_i, redirect_pc_i   taken branch/jump from execute (1-cycle pulse)
//   inst_valid_o/ready_i        decode handshake
//   inst_o, inst_pc_o, inst_fault_o  held instruction, its PC and access-fault flag
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_fault_o
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;  // outstanding response belongs to a squashed path
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] target;

  // Redirect targets are forced to word alignment; the low bits are intentionally dropped.
  assign target = {redirect_pc_i[XLEN-1:2], 2'b00};
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready_i) begin
          state_d = S_WAIT;
          if (redirect_i) begin
            // The request just accepted is already wrong-path.
            pc_d   = target;
            kill_d = 1'b1;
          end
        end else if (redirect_i) begin
          pc_d = target;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (redirect_i) begin
            pc_d    = target;
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rsp_data_i;
            fault_d   = imem_rsp_err_i;
            inst_pc_d = pc_q;
            pc_d      = pc_q + XLEN'(4);
            state_d   = S_HOLD;
          end
        end else if (redirect_i) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect wins over decode acceptance: the held word is wrong-path.
        if (redirect_i) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (inst_ready_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  // Valids are gated by reset so nothing is offered while rst is low.
  assign imem_req_valid_o = rst & (state_q == S_REQ);
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = rst & (state_q == S_HOLD) & ~redirect_i;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign inst_fault_o     = fault_q;

  // A response outside S_WAIT has no matching request; the FSM ignores it.
  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid_i |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_fault_o;

  int checks = 0;
  int failures = 0;

  fetch_ctrl #(
    .XLEN    (32),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o (imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i (imem_rsp_data_i),
    .imem_rsp_err_i  (imem_rsp_err_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_fault_o    (inst_fault_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    imem_rsp_err_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i = 1'b1;
    step();
    step();
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid_o);
    end
    checks++;
    if (inst_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid_o);
    end
    checks++;
    if (imem_req_addr_o !== 32'h8000_0000) begin
      failures++; $display("FAIL reset_pc got=%h exp=80000000", imem_req_addr_o);
    end
    checks++;
    if ({inst_o, inst_pc_o, inst_fault_o} !== 65'd0) begin
      failures++;
      $display("FAIL reset_hold_regs got=%h/%h/%b exp=0", inst_o, inst_pc_o, inst_fault_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b1) begin
      failures++; $display("FAIL release_req_valid got=%b exp=1", imem_req_valid_o);
    end
  endtask

  // Three back-to-back fetches with a 1-cycle memory and an always-ready decode.
  task automatic test_back_to_back();
    logic [31:0] addr;
    logic [31:0] data;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h8000_0000 + 32'(4 * i);
      data = 32'h0000_1013 + 32'(i << 8);
      checks++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== addr) begin
        failures++;
        $display("FAIL b2b_req%0d got=%b/%h exp=1/%h", i, imem_req_valid_o, imem_req_addr_o, addr);
      end
      step();  // handshake
      checks++;
      if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL b2b_wait%0d got=%b/%b exp=0/0", i, imem_req_valid_o, inst_valid_o);
      end
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i = data;
      step();
      imem_rsp_valid_i = 1'b0;
      checks++;
      if (inst_valid_o !== 1'b1 || inst_o !== data || inst_pc_o !== addr || inst_fault_o !== 1'b0)
      begin
        failures++;
        $display("FAIL b2b_inst%0d got=%b/%h/%h/%b exp=1/%h/%h/0", i, inst_valid_o, inst_o,
                 inst_pc_o, inst_fault_o, data, addr);
      end
      step();  // decode accepts
    end
  endtask

  task automatic test_decode_stall();
    checks++;
    if (imem_req_addr_o !== 32'h8000_000C) begin
      failures++; $display("FAIL stall_req_addr got=%h exp=8000000c", imem_req_addr_o);
    end
    inst_ready_i = 1'b0;
    step();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid_o !== 1'b1 || inst_o !== 32'hDEAD_BEEF || inst_pc_o !== 32'h8000_000C ||
          imem_req_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=1/deadbeef/8000000c/0", i,
                 inst_valid_o, inst_o, inst_pc_o, imem_req_valid_o);
      end
      step();
    end
    inst_ready_i = 1'b1;
    step();
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0010) begin
      failures++;
      $display("FAIL stall_next_req got=%b/%h exp=1/80000010", imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_redirect_wait();
    int vhigh = 0;
    step();  // handshake at 80000010
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0103;
    step();
    redirect_i = 1'b0;
    if (inst_valid_o) vhigh++;
    step();
    if (inst_valid_o) vhigh++;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'hBAD0_0001;
    step();
    imem_rsp_valid_i = 1'b0;
    if (inst_valid_o) vhigh++;
    checks++;
    if (vhigh != 0) begin
      failures++; $display("FAIL redir_wait_stale got=%0d valid cycles exp=0", vhigh);
    end
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0100) begin
      failures++;
      $display("FAIL redir_wait_req got=%b/%h exp=1/80000100", imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_redirect_handshake();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0200;
    step();  // handshake at 80000100 with redirect
    redirect_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'hBAD0_0002;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1 ||
        imem_req_addr_o !== 32'h8000_0200) begin
      failures++;
      $display("FAIL redir_hs got=%b/%b/%h exp=0/1/80000200", inst_valid_o, imem_req_valid_o,
               imem_req_addr_o);
    end
    step();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h0000_0033;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0033 || inst_pc_o !== 32'h8000_0200) begin
      failures++;
      $display("FAIL redir_hs_fetch got=%b/%h/%h exp=1/00000033/80000200", inst_valid_o, inst_o,
               inst_pc_o);
    end
  endtask

  task automatic test_redirect_hold();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0010;
    inst_ready_i = 1'b1;
    #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      failures++; $display("FAIL redir_hold_squash got=%b exp=0", inst_valid_o);
    end
    step();
    redirect_i = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0010 || inst_valid_o !== 1'b0)
    begin
      failures++;
      $display("FAIL redir_hold_req got=%b/%h/%b exp=1/80000010/0", imem_req_valid_o,
               imem_req_addr_o, inst_valid_o);
    end
  endtask

  task automatic test_fault();
    step();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_err_i = 1'b1;
    imem_rsp_data_i = 32'h0000_0000;
    step();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_fault_o !== 1'b1 || inst_pc_o !== 32'h8000_0010) begin
      failures++;
      $display("FAIL fault_inst got=%b/%b/%h exp=1/1/80000010", inst_valid_o, inst_fault_o,
               inst_pc_o);
    end
    step();
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0014) begin
      failures++;
      $display("FAIL fault_next_req got=%b/%h exp=1/80000014", imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  // Redirect without a handshake to an unaligned address near the top, then wrap.
  task automatic test_wrap();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_i = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req_valid_o, imem_req_addr_o);
    end
    imem_req_ready_i = 1'b1;
    step();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'h0000_0013;
    step();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hFFFF_FFFC || inst_fault_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_inst got=%b/%h/%b exp=1/fffffffc/0", inst_valid_o, inst_pc_o,
               inst_fault_o);
    end
    step();
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    step();  // handshake at 00000000, now waiting
    rst = 1'b0;
    step();
    checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_valids got=%b/%b exp=0/0", imem_req_valid_o, inst_valid_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000 ||
        inst_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL midrst_req got=%b/%h/%h exp=1/80000000/00000000", imem_req_valid_o,
               imem_req_addr_o, inst_pc_o);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_handshake();
    test_redirect_hold();
    test_fault();
    test_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
